seg_scan_driver: RTL and testbench

- Downstream stage of the APB GPIO block. Consumes its eight 8-bit seven-segment patterns (gpio_seg_0..7) and drives a physically multiplexed 8-digit display.
- Uses one shared active-low segment bus and active-low digit enables.
- Time-multiplexes the digits, inserts a dead-time before each digit to suppress ghosting, and snapshots all patterns once per frame so the display never tears.

---
 rtl/seg_scan_driver.sv | 111 +++++++++++
 tb/tb_seg_scan_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment scanner with per-slot dead-time and per-frame pattern snapshot.
// Define SEG_SCAN_DIM_EN to add the 3-bit PWM brightness input bright.
module seg_scan_driver #(
    parameter int DIV  = 1000,
    parameter int DEAD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] seg_in_0,
    input  logic [7:0] seg_in_1,
    input  logic [7:0] seg_in_2,
    input  logic [7:0] seg_in_3,
    input  logic [7:0] seg_in_4,
    input  logic [7:0] seg_in_5,
    input  logic [7:0] seg_in_6,
    input  logic [7:0] seg_in_7,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [7:0] seg_out,
    output logic [7:0] an_n,
    output logic       frame_start
);
    localparam int CW = $clog2(DIV);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] slot_q, slot_d;
    logic [2:0]    digit_q, digit_d;
    logic [7:0]    shadow_q [8];
    logic [7:0]    shadow_d [8];
    logic [7:0]    seg_in [8];
    logic          frame_q, frame_d, lit;
    assign seg_in = '{seg_in_0, seg_in_1, seg_in_2, seg_in_3, seg_in_4, seg_in_5, seg_in_6, seg_in_7};
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            digit_q <= '0;
            frame_q <= 1'b0;
            for (int k = 0; k < 8; k++) shadow_q[k] <= 8'hFF;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        digit_d  = digit_q;
        shadow_d = shadow_q;
        frame_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            slot_d  = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    slot_d   = '0;
                    digit_d  = '0;
                    shadow_d = seg_in;
                    frame_d  = 1'b1;
                end
                BLANK: begin
                    slot_d  = slot_q + 1'b1;
                    state_d = (slot_q == CW'(DEAD - 1)) ? SHOW : BLANK;
                end
                SHOW: begin
                    if (slot_q == CW'(DIV - 1)) begin
                        slot_d  = '0;
                        state_d = BLANK;
                        // Snapshot only at the frame wrap so a frame never mixes old and new patterns
                        if (digit_q == 3'd7) begin
                            digit_d  = '0;
                            shadow_d = seg_in;
                            frame_d  = 1'b1;
                        end else begin
                            digit_d = digit_q + 3'd1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
`ifdef SEG_SCAN_DIM_EN
    logic [2:0] pwm_q, bright_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_q    <= '0;
            bright_q <= '0;
        end else begin
            pwm_q    <= (state_q == SHOW) ? pwm_q + 3'd1 : 3'd0;
            bright_q <= bright;
        end
    end
    assign lit = (state_q == SHOW) && (pwm_q <= bright_q);
`else
    assign lit = (state_q == SHOW);
`endif
    assign an_n        = lit ? ~(8'h01 << digit_q) : 8'hFF;
    assign seg_out     = lit ? shadow_q[digit_q] : 8'hFF;
    assign frame_start = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: time-indexed reference model feeding a scoreboard, plus checkpoint table and corner-case sequences.
module tb_seg_scan_driver;
    localparam int DIV = 10, DEAD = 2, FRAME = 8 * DIV;
    logic       clock = 1'b0, reset = 1'b1, en = 1'b0;
    logic [7:0] seg_in [8];
    logic [7:0] seg_out, an_n;
    logic       frame_start;
`ifdef SEG_SCAN_DIM_EN
    logic [2:0] bright = 3'd7;
`endif
    always #5 clock = ~clock;
    seg_scan_driver #(.DIV(DIV), .DEAD(DEAD)) dut (
        .clock(clock), .reset(reset), .en(en),
        .seg_in_0(seg_in[0]), .seg_in_1(seg_in[1]), .seg_in_2(seg_in[2]), .seg_in_3(seg_in[3]),
        .seg_in_4(seg_in[4]), .seg_in_5(seg_in[5]), .seg_in_6(seg_in[6]), .seg_in_7(seg_in[7]),
`ifdef SEG_SCAN_DIM_EN
        .bright(bright),
`endif
        .seg_out(seg_out), .an_n(an_n), .frame_start(frame_start)
    );
    typedef struct packed {logic [7:0] an; logic [7:0] seg; logic fs;} out_t;
    typedef struct {int t; logic [7:0] an; logic [7:0] seg; logic fs;} vec_t;
    out_t       q[$];
    out_t       last;
    vec_t       tbl[11];
    int         n_cmp = 0, n_bad = 0;
    bit         m_run = 0;
    int         m_abs = 0;
    logic [7:0] m_sh [8];
    function automatic out_t model_step();
        int slot, d;
        logic lit;
        logic [7:0] one;
        if (reset) begin
            m_run = 0;
            for (int k = 0; k < 8; k++) m_sh[k] = 8'hFF;
        end else if (!en) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_abs = 0;
            for (int k = 0; k < 8; k++) m_sh[k] = seg_in[k];
        end else begin
            m_abs++;
            if (m_abs % FRAME == 0) for (int k = 0; k < 8; k++) m_sh[k] = seg_in[k];
        end
        if (!m_run) return '{8'hFF, 8'hFF, 1'b0};
        slot = m_abs % DIV;
        d    = (m_abs / DIV) % 8;
        lit  = slot >= DEAD;
`ifdef SEG_SCAN_DIM_EN
        lit = lit && (((slot - DEAD) % 8) <= int'(bright));
`endif
        one = 8'h01 << d;
        return '{lit ? ~one : 8'hFF, lit ? m_sh[d] : 8'hFF, (m_abs % FRAME) == 0};
    endfunction
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t (run cycle %0d): got %h expected %h", nm, $time, m_abs, act, exp);
        end
    endtask
    task automatic cyc();
        out_t e;
        q.push_back(model_step());
        @(posedge clock);
        @(negedge clock);
        e    = q.pop_front();
        last = '{an_n, seg_out, frame_start};
        chk("sb_an_n", an_n, e.an);
        chk("sb_seg_out", seg_out, e.seg);
        chk("sb_frame_start", {7'd0, frame_start}, {7'd0, e.fs});
    endtask
    task automatic run_to(input int t);
        int g = 0;
        while (!(m_run && m_abs == t) && g < 1000) begin
            cyc();
            g++;
        end
        if (g >= 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_to: cycle %0d not reached, got %0d", t, m_abs);
        end
    endtask
    task automatic count_lit(input int start, output int n);
        run_to(start);
        n = 0;
        for (int i = 0; i < DIV; i++) begin
            if (last.an !== 8'hFF) n++;
            cyc();
        end
    endtask
    initial begin
        int n;
        tbl[0]  = '{0,   8'hFF, 8'hFF, 1'b1};
        tbl[1]  = '{1,   8'hFF, 8'hFF, 1'b0};
        tbl[2]  = '{2,   8'hFE, 8'h10, 1'b0};
        tbl[3]  = '{9,   8'hFE, 8'h10, 1'b0};
        tbl[4]  = '{10,  8'hFF, 8'hFF, 1'b0};
        tbl[5]  = '{12,  8'hFD, 8'h11, 1'b0};
        tbl[6]  = '{72,  8'h7F, 8'h17, 1'b0};
        tbl[7]  = '{79,  8'h7F, 8'h17, 1'b0};
        tbl[8]  = '{80,  8'hFF, 8'hFF, 1'b1};
        tbl[9]  = '{82,  8'hFE, 8'h10, 1'b0};
        tbl[10] = '{160, 8'hFF, 8'hFF, 1'b1};
        for (int k = 0; k < 8; k++) seg_in[k] = 8'h10 + 8'(k);
        @(negedge clock);
        for (int i = 0; i < 3; i++) cyc();
        chk("reset_an_n", last.an, 8'hFF);
        chk("reset_seg_out", last.seg, 8'hFF);
        chk("reset_frame_start", {7'd0, last.fs}, 8'd0);
        reset = 1'b0;
        cyc();
        en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_to(tbl[i].t);
            chk($sformatf("tbl%0d_an_n", i), last.an, tbl[i].an);
            chk($sformatf("tbl%0d_seg_out", i), last.seg, tbl[i].seg);
            chk($sformatf("tbl%0d_frame_start", i), {7'd0, last.fs}, {7'd0, tbl[i].fs});
        end
        run_to(172);
        seg_in[3] = 8'hAA;
        run_to(192);
        chk("tear_old_an_n", last.an, 8'hF7);
        chk("tear_old_seg", last.seg, 8'h13);
        run_to(272);
        chk("tear_new_seg", last.seg, 8'hAA);
        run_to(282);
        en = 1'b0;
        cyc();
        chk("en_off_an_n", last.an, 8'hFF);
        chk("en_off_seg", last.seg, 8'hFF);
        cyc();
        cyc();
        en = 1'b1;
        cyc();
        chk("restart_frame_start", {7'd0, last.fs}, 8'd1);
        chk("restart_blank_an", last.an, 8'hFF);
        cyc();
        cyc();
        chk("restart_digit0_an", last.an, 8'hFE);
        chk("restart_digit0_seg", last.seg, 8'h10);
        run_to(62);
        reset = 1'b1;
        cyc();
        chk("rst_mid_an_n", last.an, 8'hFF);
        chk("rst_mid_seg", last.seg, 8'hFF);
        chk("rst_mid_fs", {7'd0, last.fs}, 8'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_restart_fs", {7'd0, last.fs}, 8'd1);
        run_to(2);
        chk("rst_restart_an", last.an, 8'hFE);
        chk("rst_restart_seg", last.seg, 8'h10);
`ifdef SEG_SCAN_DIM_EN
        bright = 3'd1;
        count_lit(100, n);
        chk("dim_bright1_lit", 8'(n), 8'd2);
        bright = 3'd7;
        count_lit(120, n);
        chk("dim_bright7_lit", 8'(n), 8'd8);
        bright = 3'd0;
        count_lit(140, n);
        chk("dim_bright0_lit", 8'(n), 8'd1);
        bright = 3'd7;
`endif
        run_to(FRAME + 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
